store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of pending-store entries (power of two, 2..16).
REQ-002 Parameter IDXW, default 12, word-index bits compared for address match (addr[IDXW+1:2]).
REQ-003 clk  in  1  system clock; all state updates on posedge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 st_valid  in  1  MEM stage presents a store this cycle.
REQ-006 st_addr  in  32  store byte address (word aligned).
REQ-007 st_data  in  32  store data.
REQ-008 ld_valid  in  1  MEM stage presents a load this cycle.
REQ-009 ld_addr  in  32  load byte address (word aligned).
REQ-010 ld_data  out  32  load result to pipeline, forwarded or from dmem.
REQ-011 stall  out  1  store not accepted; MEM stage holds.
REQ-012 fence  in  1  request drain of all entries.
REQ-013 empty  out  1  buffer holds zero entries.
REQ-014 mem_we  out  1  write enable to dmem.
REQ-015 mem_a  out  32  address to dmem.
REQ-016 mem_wd  out  32  write data to dmem.
REQ-017 mem_rd  in  32  combinational read data from dmem.

Function
REQ-018 The block SHALL hold a circular FIFO of DEPTH entries {addr, data} with head/tail pointers and a count of 0..DEPTH.
REQ-019 A store SHALL be enqueued at the posedge where st_valid=1 and stall=0.
REQ-020 stall SHALL equal st_valid AND (count==DEPTH); no same-cycle pop bypass.
REQ-021 Port arbitration: if ld_valid=1, mem_a=ld_addr, mem_we=0, no drain that cycle.
REQ-022 If ld_valid=0 and count>0: mem_a=head.addr, mem_wd=head.data, mem_we=1, and head SHALL pop at that posedge.
REQ-023 If ld_valid=0 and count==0: mem_we=0, mem_a=0, mem_wd=0.
REQ-024 Load forwarding: ld_data SHALL be the data of the youngest valid entry whose addr[IDXW+1:2] equals ld_addr[IDXW+1:2], else mem_rd; zero latency.
REQ-025 A store enqueued in the same cycle as a load SHALL NOT be visible to that load.
REQ-026 Simultaneous enqueue and pop SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-027 While fence=1, stores SHALL stall (stall=st_valid), draining continues; empty SHALL be count==0.
REQ-028 Loads SHALL never stall; consecutive loads starve draining with no timeout.
REQ-029 Duplicate addresses SHALL be kept as separate entries and drained in order.

Reset
REQ-030 On rst=1 at posedge: count=0, head=0, tail=0; entry storage need not clear.
REQ-031 After reset: empty=1, mem_we=0, stall=0, mem_a=ld_addr when ld_valid else 0.
REQ-032 rst mid-drain SHALL discard all pending entries; no write issued in the reset cycle (mem_we gated by rst).

Structure
REQ-033 Package sb_pkg SHALL hold DEPTH/IDXW defaults and typedef sb_entry_t {logic [31:0] addr; logic [31:0] data;}.
REQ-034 Youngest-match priority search SHALL be a sub-module sb_fwd_match (entries, head, count, ld_addr -> hit, data).

Verification
REQ-035 Reset, store A=0x10/D=0x11 with ld_valid=0 -> next cycle mem_we=1, mem_a=0x10, mem_wd=0x11; then empty=1.
REQ-036 Four stores (0x0,0x4,0x8,0xC) under continuous loads, fifth store -> stall=1, count=4, no write.
REQ-037 Stores 0x20=0xAA then 0x20=0xBB, load 0x20 -> ld_data=0xBB; after drain load -> mem_rd=0xBB.
REQ-038 Load 0x40 with no match -> ld_data=mem_rd, mem_we=0 that cycle.
REQ-039 fence=1 with count=3, ld_valid=0 -> three writes on consecutive cycles in FIFO order, empty=1 on cycle 3.
REQ-040 rst with count=2 -> next cycle empty=1, mem_we=0, stale addresses not forwarded.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared defaults and entry type for the store buffer.
package sb_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_IDXW  = 12;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match search over the valid window of the store FIFO.
module sb_fwd_match
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int IDXW  = SB_IDXW,
  localparam int PW   = $clog2(DEPTH)
) (
  input  sb_entry_t         entries [DEPTH],
  input  logic [PW-1:0]     head,
  input  logic [PW:0]       count,
  input  logic [31:0]       ld_addr,
  output logic              hit,
  output logic [31:0]       data
);

  logic [PW-1:0] idx;
  logic          unused_bits;

  // Walk from oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (((PW+1)'(i) < count) &&
          (entries[idx].addr[IDXW+1:2] == ld_addr[IDXW+1:2])) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

  // Address bits outside the compared word index do not take part in matching.
  always_comb begin
    unused_bits = ^{ld_addr[31:IDXW+2], ld_addr[1:0]};
    for (int i = 0; i < DEPTH; i++) begin
      unused_bits = unused_bits ^ (^entries[i]);
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Post-commit store buffer: queues stores, drains them to dmem when the
// load port is idle, and forwards the youngest matching store to loads.
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int IDXW  = SB_IDXW
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic [31:0] ld_data,
  output logic        stall,
  input  logic        fence,
  output logic        empty,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam int PW = $clog2(DEPTH);

  sb_entry_t     entries_q [DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [PW:0]   count_q;

  logic          full;
  logic          has_entry;
  logic          push;
  logic          pop;
  logic          fwd_hit;
  logic [31:0]   fwd_data;

  assign full      = (count_q == (PW+1)'(DEPTH));
  assign has_entry = (count_q != '0);
  assign empty     = ~has_entry;

  // A fence blocks new stores so the buffer can only shrink.
  assign stall = st_valid & (full | fence);
  assign push  = st_valid & ~stall;
  // Loads own the dmem port; reset suppresses any write in its cycle.
  assign pop   = ~ld_valid & has_entry & ~rst;

  // dmem port arbitration: load address first, otherwise drain the head.
  always_comb begin
    mem_we = 1'b0;
    mem_a  = '0;
    mem_wd = '0;
    if (ld_valid) begin
      mem_a = ld_addr;
    end else if (has_entry) begin
      mem_a  = entries_q[head_q].addr;
      mem_wd = entries_q[head_q].data;
      mem_we = pop;
    end
  end

  sb_fwd_match #(
    .DEPTH (DEPTH),
    .IDXW  (IDXW)
  ) u_fwd (
    .entries (entries_q),
    .head    (head_q),
    .count   (count_q),
    .ld_addr (ld_addr),
    .hit     (fwd_hit),
    .data    (fwd_data)
  );

  assign ld_data = fwd_hit ? fwd_data : mem_rd;

  // Entry storage is never cleared; validity comes from head/count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      entries_q[tail_q] <= '{addr: st_addr, data: st_data};
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed and randomized checks of store_buffer against a queue-based model.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, st_valid, ld_valid, fence;
  logic [31:0] st_addr, st_data, ld_addr;
  logic [31:0] ld_data, mem_a, mem_wd, mem_rd;
  logic        stall, empty, mem_we;

  store_buffer #(.DEPTH(DEPTH), .IDXW(12)) dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_addr(st_addr),
    .st_data(st_data), .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_data(ld_data), .stall(stall), .fence(fence), .empty(empty),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Data memory seen by the DUT, written only through its port.
  logic [31:0] dut_mem [64];
  assign mem_rd = dut_mem[mem_a[7:2]];
  always @(posedge clk) if (mem_we) dut_mem[mem_a[7:2]] <= mem_wd;

  // Reference model: ordered list of pending stores plus its own memory.
  typedef struct { logic [31:0] a; logic [31:0] d; } ent_t;
  ent_t        q[$];
  logic [31:0] ref_mem [64];

  int total = 0;
  int fails = 0;

  logic exp_stall, exp_we;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] a);
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].a[13:2] == a[13:2]) return q[i].d;
    return ref_mem[a[7:2]];
  endfunction

  // Drive one cycle's inputs and check all combinational outputs vs model.
  task automatic apply(input bit sv, input logic [31:0] sa, input logic [31:0] sd,
                       input bit lv, input logic [31:0] la, input bit fn, input bit rs);
    st_valid = sv; st_addr = sa; st_data = sd;
    ld_valid = lv; ld_addr = la; fence = fn; rst = rs;
    #1;
    exp_stall = sv && (q.size() == DEPTH || fn);
    exp_we    = !lv && q.size() > 0 && !rs;
    chk("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
    if (!rs) begin
      chk("stall", {31'd0, stall}, {31'd0, exp_stall});
      chk("empty", {31'd0, empty}, {31'd0, q.size() == 0});
      if (lv) begin
        chk("mem_a_ld", mem_a, la);
        chk("ld_data", ld_data, ref_load(la));
      end else if (q.size() > 0) begin
        chk("mem_a_drain", mem_a, q[0].a);
        chk("mem_wd_drain", mem_wd, q[0].d);
      end else begin
        chk("mem_a_idle", mem_a, 32'h0);
        chk("mem_wd_idle", mem_wd, 32'h0);
      end
    end
  endtask

  // Advance one clock and update the model from this cycle's decisions.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      q.delete();
    end else begin
      if (exp_we) begin
        ref_mem[q[0].a[7:2]] = q[0].d;
        void'(q.pop_front());
      end
      if (st_valid && !exp_stall) q.push_back('{a: st_addr, d: st_data});
    end
    @(negedge clk);
  endtask

  task automatic step(input bit sv, input logic [31:0] sa, input logic [31:0] sd,
                      input bit lv, input logic [31:0] la, input bit fn, input bit rs);
    apply(sv, sa, sd, lv, la, fn, rs);
    tick();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin dut_mem[i] = '0; ref_mem[i] = '0; end
    st_valid = 0; st_addr = 0; st_data = 0; ld_valid = 0; ld_addr = 0;
    fence = 0; rst = 1;
    @(negedge clk);

    // Reset and post-reset idle state.
    step(0, 0, 0, 0, 0, 0, 1);
    apply(0, 0, 0, 0, 0, 0, 0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    tick();

    // Single store drains the next cycle.
    step(1, 32'h10, 32'h11, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0);
    chk("drain_we", {31'd0, mem_we}, 32'd1);
    chk("drain_a", mem_a, 32'h10);
    chk("drain_wd", mem_wd, 32'h11);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0);
    chk("drain_empty", {31'd0, empty}, 32'd1);
    tick();

    // Fill under continuous loads, fifth store stalls with no write.
    for (int i = 0; i < 4; i++) step(1, 32'(i * 4), 32'(100 + i), 1, 32'h80, 0, 0);
    apply(1, 32'h30, 32'h55, 1, 32'h80, 0, 0);
    chk("full_stall", {31'd0, stall}, 32'd1);
    chk("full_no_we", {31'd0, mem_we}, 32'd0);
    tick();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0);

    // Duplicate addresses: youngest forwarded, then read back from memory.
    step(1, 32'h20, 32'hAA, 1, 32'h80, 0, 0);
    step(1, 32'h20, 32'hBB, 1, 32'h80, 0, 0);
    apply(0, 0, 0, 1, 32'h20, 0, 0);
    chk("fwd_young", ld_data, 32'hBB);
    tick();
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 1, 32'h20, 0, 0);
    chk("mem_after_drain", ld_data, 32'hBB);
    tick();

    // Store in the same cycle as a load is invisible to it.
    apply(1, 32'h40, 32'h77, 1, 32'h40, 0, 0);
    chk("same_cycle_ld", ld_data, 32'h0);
    tick();
    step(0, 0, 0, 0, 0, 0, 0);

    // Fence with three pending stores drains in order while stalling stores.
    for (int i = 0; i < 3; i++) step(1, 32'(32'h50 + i * 4), 32'(200 + i), 1, 32'h80, 0, 0);
    for (int i = 0; i < 3; i++) begin
      apply(1, 32'hF0, 32'h99, 0, 0, 1, 0);
      chk("fence_order", mem_a, 32'(32'h50 + i * 4));
      tick();
    end
    apply(0, 0, 0, 0, 0, 1, 0);
    chk("fence_empty", {31'd0, empty}, 32'd1);
    tick();

    // Reset with two pending stores discards them.
    step(1, 32'h60, 32'h1234, 1, 32'h80, 0, 0);
    step(1, 32'h64, 32'h5678, 1, 32'h80, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 1);
    chk("rst_no_we", {31'd0, mem_we}, 32'd0);
    tick();
    apply(0, 0, 0, 1, 32'h60, 0, 0);
    chk("rst_stale", ld_data, 32'h0);
    tick();

    // Randomized traffic over a small address window to provoke matches.
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 1), 32'($urandom_range(0, 15) * 4), $urandom,
           ($urandom_range(0, 9) < 4), 32'($urandom_range(0, 15) * 4),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0));
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
